// File: rtl/bumpy_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bumpy_motion_pkg
// Purpose  : Shared state encoding, edge indices and fixed-point types for
//            the bumpy sprite motion block.
// Revision : 1.0 - initial release
// ============================================================================
package bumpy_motion_pkg;

    typedef enum logic [1:0] {
        ST_SPAWN = 2'd0,
        ST_AIR   = 2'd1,
        ST_HOP   = 2'd2
    } motion_state_t;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;

    localparam int DEF_FRAC_BITS = 6;
    localparam int DEF_POS_W     = 11;
    localparam int DEF_SPD_W     = 12;

    typedef logic signed [DEF_SPD_W-1:0]               speed_t;
    typedef logic signed [DEF_POS_W+DEF_FRAC_BITS:0]   pos_fp_t;

endpackage
`default_nettype wire

// File: rtl/bumpy_event_latch.sv
`default_nettype none
// ============================================================================
// Module   : bumpy_event_latch
// Purpose  : Frame-long sticky collision edges with same-cycle bypass, plus
//            the jump buffer when BUMPY_JUMP_BUFFER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module bumpy_event_latch
`ifdef BUMPY_JUMP_BUFFER_EN
#(
    parameter int BUF_FRAMES = 4
)
`endif
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sof,
    input  logic       i_respawn,
    input  logic       i_collision,
    input  logic [3:0] i_edge_code,
`ifdef BUMPY_JUMP_BUFFER_EN
    input  logic       i_jumpN,
    input  logic       i_jump_taken,
    output logic       o_jump_buf,
`endif
    output logic [3:0] o_hit
);

    logic [3:0] r_hit;

    // The current cycle's edges join the decision even on the frame boundary.
    assign o_hit = r_hit | (i_collision ? i_edge_code : 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit <= 4'b0000;
        end else if (i_sof || i_respawn) begin
            r_hit <= 4'b0000;
        end else if (i_collision) begin
            r_hit <= r_hit | i_edge_code;
        end
    end

`ifdef BUMPY_JUMP_BUFFER_EN
    localparam int CNT_W = $clog2(BUF_FRAMES + 1);

    logic             r_jump_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fall;

    assign w_fall     = r_jump_q & ~i_jumpN;
    assign o_jump_buf = (r_cnt != '0) | w_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jump_q <= 1'b1;
            r_cnt    <= '0;
        end else begin
            r_jump_q <= i_jumpN;
            if (i_respawn || i_jump_taken) begin
                r_cnt <= '0;
            end else if (w_fall) begin
                r_cnt <= CNT_W'(BUF_FRAMES);
            end else if (i_sof && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/bumpy_motion_fsm.sv
`default_nettype none
// ============================================================================
// Module   : bumpy_motion_fsm
// Purpose  : Fixed-point bouncing, tile-hopping sprite state machine with
//            frame-latched collisions. Optional macro: BUMPY_JUMP_BUFFER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bumpy_motion_fsm
    import bumpy_motion_pkg::*;
#(
    parameter int FRAC_BITS     = 6,
    parameter int POS_W         = 11,
    parameter int SPD_W         = 12,
    parameter int TILE_W        = 80,
    parameter int SPRITE_OFS    = 24,
    parameter int GRAVITY       = 3,
    parameter int SIDE_SPEED    = 74,
    parameter int JUMP_UP_SPEED = 200,
    parameter int STEP_SPEED    = 100,
    parameter int FALL_LIMIT    = 170,
    parameter int RISE_LIMIT    = 170,
    parameter int BUF_FRAMES    = 4
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_of_frame,
    input  logic                    rightN,
    input  logic                    leftN,
    input  logic                    jumpN,
    input  logic                    collision,
    input  logic [3:0]              HitEdgeCode,
    input  logic                    respawn,
    input  logic [2:0]              spawn_col,
    input  logic [2:0]              spawn_row,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic [1:0]              state_o,
    output logic                    landed
);

    localparam int PW = POS_W + FRAC_BITS + 1;

    typedef logic signed [PW-1:0]    fp_t;
    typedef logic signed [SPD_W-1:0] spd_t;
    typedef logic signed [SPD_W:0]   spdw_t;

    localparam spd_t  c_zero    = '0;
    localparam spd_t  c_gravity = spd_t'(GRAVITY);
    localparam spd_t  c_side    = spd_t'(SIDE_SPEED);
    localparam spd_t  c_jump    = spd_t'(JUMP_UP_SPEED);
    localparam spd_t  c_step    = spd_t'(STEP_SPEED);
    localparam spdw_t c_rise_w  = spdw_t'(RISE_LIMIT);
    localparam spdw_t c_fall_w  = spdw_t'(FALL_LIMIT);
    localparam fp_t   c_ofs_fp  = fp_t'(SPRITE_OFS) <<< FRAC_BITS;

    function automatic spdw_t wide(input spd_t v);
        return {v[SPD_W-1], v};
    endfunction

    function automatic fp_t to_fp(input spd_t v);
        return {{(PW-SPD_W){v[SPD_W-1]}}, v};
    endfunction

    function automatic spd_t sat(input spdw_t v);
        if (v > c_rise_w)
            return spd_t'(c_rise_w);
        else if (v < -c_fall_w)
            return spd_t'(-c_fall_w);
        else
            return spd_t'(v);
    endfunction

    motion_state_t r_state, w_state_n;
    spd_t          r_vx, r_vy, w_vx_n, w_vy_n;
    fp_t           r_pos_x, r_pos_y;
    fp_t           w_px_next, w_py_next, w_px_dec, w_snap_x, w_xpix;
    fp_t           w_spawn_x, w_spawn_y;
    logic          r_landed, w_land, w_jump;
    logic [3:0]    w_hit;
    int            w_rem;

`ifdef BUMPY_JUMP_BUFFER_EN
    logic w_jump_buf;

    assign w_jump = ~jumpN | w_jump_buf;

    bumpy_event_latch #(
        .BUF_FRAMES (BUF_FRAMES)
    ) u_latch (
        .clk          (clk),
        .reset        (reset),
        .i_sof        (start_of_frame),
        .i_respawn    (respawn),
        .i_collision  (collision),
        .i_edge_code  (HitEdgeCode),
        .i_jumpN      (jumpN),
        .i_jump_taken (w_land & w_jump & start_of_frame),
        .o_jump_buf   (w_jump_buf),
        .o_hit        (w_hit)
    );
`else
    assign w_jump = ~jumpN;

    bumpy_event_latch u_latch (
        .clk         (clk),
        .reset       (reset),
        .i_sof       (start_of_frame),
        .i_respawn   (respawn),
        .i_collision (collision),
        .i_edge_code (HitEdgeCode),
        .o_hit       (w_hit)
    );
`endif

    assign w_spawn_x = fp_t'(int'(spawn_col) * TILE_W + SPRITE_OFS) <<< FRAC_BITS;
    assign w_spawn_y = fp_t'(int'(spawn_row) * TILE_W + SPRITE_OFS) <<< FRAC_BITS;
    assign w_px_next = r_pos_x + to_fp(r_vx);
    assign w_py_next = r_pos_y - to_fp(r_vy);

    // Tile snap uses a floor modulo so negative X still lands on a tile slot.
    always_comb begin
        w_xpix = w_px_next >>> FRAC_BITS;
        w_rem  = int'(w_xpix) % TILE_W;
        if (w_rem < 0)
            w_rem = w_rem + TILE_W;
        w_snap_x = fp_t'(int'(w_xpix) - w_rem + SPRITE_OFS) <<< FRAC_BITS;
    end

    always_comb begin
        w_state_n = r_state;
        w_vx_n    = r_vx;
        w_vy_n    = r_vy;
        w_land    = 1'b0;
        w_px_dec  = w_px_next;
        case (r_state)
            ST_SPAWN: begin
                w_state_n = ST_AIR;
                w_vx_n    = c_zero;
                w_vy_n    = c_zero;
            end
            ST_AIR, ST_HOP: begin
                if (w_hit[EDGE_BOTTOM] && (r_vy <= c_zero)) begin
                    w_land   = 1'b1;
                    w_px_dec = w_snap_x;
                    // Launch speeds are loaded as-is; only arithmetic results are clamped.
                    if (w_jump) begin
                        w_state_n = ST_AIR;
                        w_vx_n    = c_zero;
                        w_vy_n    = c_jump;
                    end else if (!rightN) begin
                        w_state_n = ST_HOP;
                        w_vx_n    = c_side;
                        w_vy_n    = c_step;
                    end else if (!leftN) begin
                        w_state_n = ST_HOP;
                        w_vx_n    = -c_side;
                        w_vy_n    = c_step;
                    end else begin
                        w_state_n = ST_AIR;
                        w_vx_n    = c_zero;
                        w_vy_n    = c_step;
                    end
                end else begin
                    if (w_hit[EDGE_TOP] && (r_vy > c_zero)) begin
                        w_vy_n = sat(-wide(r_vy));
                        if (r_state == ST_HOP)
                            w_vx_n = -r_vx;
                    end else if ((r_state == ST_HOP) &&
                                 ((w_hit[EDGE_RIGHT] && (r_vx > c_zero)) ||
                                  (w_hit[EDGE_LEFT]  && (r_vx < c_zero)))) begin
                        w_vx_n = -r_vx;
                    end else begin
                        w_vy_n = sat(wide(r_vy) - wide(c_gravity));
                    end
                    if (r_state == ST_AIR)
                        w_vx_n = c_zero;
                    if ((r_state == ST_HOP) && (w_vy_n <= -c_step)) begin
                        w_state_n = ST_AIR;
                        w_vx_n    = c_zero;
                    end
                end
            end
            default: begin
                w_state_n = ST_SPAWN;
                w_vx_n    = c_zero;
                w_vy_n    = c_zero;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_SPAWN;
            r_vx     <= c_zero;
            r_vy     <= c_zero;
            r_pos_x  <= c_ofs_fp;
            r_pos_y  <= c_ofs_fp;
            r_landed <= 1'b0;
        end else if (respawn) begin
            r_state  <= ST_SPAWN;
            r_vx     <= c_zero;
            r_vy     <= c_zero;
            r_pos_x  <= w_spawn_x;
            r_pos_y  <= w_spawn_y;
            r_landed <= 1'b0;
        end else if (start_of_frame) begin
            r_state  <= w_state_n;
            r_vx     <= w_vx_n;
            r_vy     <= w_vy_n;
            r_pos_x  <= w_px_dec;
            r_pos_y  <= w_py_next;
            r_landed <= w_land;
        end else begin
            r_landed <= 1'b0;
        end
    end

    assign topLeftX = POS_W'(r_pos_x >>> FRAC_BITS);
    assign topLeftY = POS_W'(r_pos_y >>> FRAC_BITS);
    assign state_o  = r_state;
    assign landed   = r_landed;

endmodule
`default_nettype wire

// File: tb/tb_bumpy_motion_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_bumpy_motion_fsm
// Purpose  : Directed and randomized self-checking bench for bumpy_motion_fsm
//            against an integer behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bumpy_motion_fsm;

    localparam int BUF_FRAMES = 4;
`ifdef BUMPY_JUMP_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, start_of_frame, rightN, leftN, jumpN, collision, respawn;
    logic [3:0]        HitEdgeCode;
    logic [2:0]        spawn_col, spawn_row;
    logic signed [10:0] topLeftX, topLeftY;
    logic [1:0]        state_o;
    logic              landed;

    int n_checks = 0;
    int n_errors = 0;

    // integer model of the sprite: positions in 1/64 px
    int m_st, m_vx, m_vy, m_x, m_y, m_hit, m_land, sofs, tap;

    always #5 clk = ~clk;

    bumpy_motion_fsm dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (start_of_frame),
        .rightN         (rightN),
        .leftN          (leftN),
        .jumpN          (jumpN),
        .collision      (collision),
        .HitEdgeCode    (HitEdgeCode),
        .respawn        (respawn),
        .spawn_col      (spawn_col),
        .spawn_row      (spawn_row),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .state_o        (state_o),
        .landed         (landed)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        if (v > 170) return 170;
        if (v < -170) return -170;
        return v;
    endfunction

    function automatic int px11(input int fp);
        logic signed [10:0] t;
        t = 11'(fp >>> 6);
        return int'(t);
    endfunction

    task automatic model_respawn();
        m_st = 0; m_vx = 0; m_vy = 0; m_hit = 0; m_land = 0; tap = -1;
        m_x = (int'(spawn_col) * 80 + 24) * 64;
        m_y = (int'(spawn_row) * 80 + 24) * 64;
    endtask

    task automatic model_sof(input int hit_now);
        int h, nx, ny, px, r;
        bit jmp;
        h = m_hit | hit_now;
        nx = m_x + m_vx;
        ny = m_y - m_vy;
        sofs++;
        jmp = !jumpN || (BUF_EN && tap >= 0 && (sofs - tap) <= BUF_FRAMES);
        m_land = 0;
        if (m_st == 0) begin
            m_st = 1; m_vx = 0; m_vy = 0;
        end else if ((h & 1) != 0 && m_vy <= 0) begin
            m_land = 1;
            px = nx >>> 6;
            r = px % 80;
            if (r < 0) r += 80;
            nx = (px - r + 24) * 64;
            if (jmp) begin
                m_st = 1; m_vx = 0; m_vy = 200; tap = -1;
            end else if (!rightN) begin
                m_st = 2; m_vx = 74; m_vy = 100;
            end else if (!leftN) begin
                m_st = 2; m_vx = -74; m_vy = 100;
            end else begin
                m_st = 1; m_vx = 0; m_vy = 100;
            end
        end else begin
            if ((h & 4) != 0 && m_vy > 0) begin
                m_vy = sat(-m_vy);
                if (m_st == 2) m_vx = -m_vx;
            end else if (m_st == 2 && (((h & 2) != 0 && m_vx > 0) || ((h & 8) != 0 && m_vx < 0))) begin
                m_vx = -m_vx;
            end else begin
                m_vy = sat(m_vy - 3);
            end
            if (m_st == 2 && m_vy <= -100) begin
                m_st = 1; m_vx = 0;
            end
        end
        m_x = nx; m_y = ny; m_hit = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, int'(state_o), m_st);
        chk({tag, ".vx"}, int'(dut.r_vx), m_vx);
        chk({tag, ".vy"}, int'(dut.r_vy), m_vy);
        chk({tag, ".x"}, int'(topLeftX), px11(m_x));
        chk({tag, ".y"}, int'(topLeftY), px11(m_y));
        chk({tag, ".landed"}, int'(landed), m_land);
    endtask

    task automatic set_keys(input logic r, input logic l, input logic j);
        if (jumpN == 1'b1 && j == 1'b0) tap = sofs;
        rightN = r; leftN = l; jumpN = j;
    endtask

    task automatic clk_cycle(input logic col, input logic [3:0] code);
        collision = col; HitEdgeCode = code;
        if (col) m_hit |= int'(code);
        @(posedge clk); #1;
        collision = 1'b0; HitEdgeCode = 4'b0000;
    endtask

    task automatic do_respawn(input string tag);
        respawn = 1'b1;
        model_respawn();
        @(posedge clk); #1;
        respawn = 1'b0;
        check_all(tag);
    endtask

    task automatic do_sof(input string tag, input logic col, input logic [3:0] code, input logic resp);
        start_of_frame = 1'b1; collision = col; HitEdgeCode = code; respawn = resp;
        if (resp) model_respawn();
        else model_sof(col ? int'(code) : 0);
        @(posedge clk); #1;
        start_of_frame = 1'b0; collision = 1'b0; HitEdgeCode = 4'b0000; respawn = 1'b0;
        check_all(tag);
        clk_cycle(1'b0, 4'b0000);
        chk({tag, ".landed_clr"}, int'(landed), 0);
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) begin
            clk_cycle(1'b0, 4'b0000);
            do_sof("idle", 1'b0, 4'b0000, 1'b0);
        end
    endtask

    task automatic fall_until_down();
        for (int i = 0; i < 100 && m_vy > 0; i++) idle_frames(1);
    endtask

    initial begin
        reset = 1'b1; start_of_frame = 1'b0; rightN = 1'b1; leftN = 1'b1; jumpN = 1'b1;
        collision = 1'b0; HitEdgeCode = 4'b0000; respawn = 1'b0; spawn_col = 3'd0; spawn_row = 3'd0;
        m_st = 0; m_vx = 0; m_vy = 0; m_x = 24 * 64; m_y = 24 * 64; m_hit = 0; m_land = 0;
        sofs = 0; tap = -1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_all("reset");
        chk("reset.x_px", int'(topLeftX), 24);

        // gravity and fall clamp
        do_sof("to_air", 1'b0, 4'b0000, 1'b0);
        chk("to_air.vy", int'(dut.r_vy), 0);
        idle_frames(56);
        chk("grav56", int'(dut.r_vy), -168);
        idle_frames(1);
        chk("grav57_clamp", int'(dut.r_vy), -170);
        idle_frames(1);
        chk("grav58_hold", int'(dut.r_vy), -170);

        // plain landing, no keys
        clk_cycle(1'b1, 4'b0001);
        clk_cycle(1'b0, 4'b0000);
        do_sof("land", 1'b0, 4'b0000, 1'b0);
        chk("land.vy", int'(dut.r_vy), 100);

        // hop right, side reversal, hop exit to AIR
        fall_until_down();
        set_keys(1'b0, 1'b1, 1'b1);
        clk_cycle(1'b0, 4'b0000);
        do_sof("hop_start", 1'b1, 4'b0001, 1'b0);
        chk("hop.state", int'(state_o), 2);
        chk("hop.vx", int'(dut.r_vx), 74);
        chk("hop.vy", int'(dut.r_vy), 100);
        set_keys(1'b1, 1'b1, 1'b1);
        idle_frames(5);
        clk_cycle(1'b1, 4'b0010);
        do_sof("side_hit", 1'b0, 4'b0000, 1'b0);
        chk("side_hit.vx", int'(dut.r_vx), -74);
        for (int i = 0; i < 100 && m_st == 2; i++) idle_frames(1);
        chk("hop_exit.state", int'(state_o), 1);
        chk("hop_exit.vx", int'(dut.r_vx), 0);

        // landing snap from a non-tile X
        clk_cycle(1'b1, 4'b0001);
        do_sof("snap", 1'b0, 4'b0000, 1'b0);
        chk("snap.mod", ((int'(topLeftX) % 80) + 80) % 80, 24);

        // jump beats side key
        fall_until_down();
        set_keys(1'b1, 1'b0, 1'b0);
        clk_cycle(1'b0, 4'b0000);
        do_sof("jump", 1'b1, 4'b0001, 1'b0);
        chk("jump.vy", int'(dut.r_vy), 200);
        chk("jump.vx", int'(dut.r_vx), 0);
        chk("jump.state", int'(state_o), 1);
        set_keys(1'b1, 1'b1, 1'b1);

        // respawn coincident with SOF in the middle of a hop
        fall_until_down();
        set_keys(1'b1, 1'b0, 1'b1);
        clk_cycle(1'b0, 4'b0000);
        do_sof("hop_left", 1'b1, 4'b0001, 1'b0);
        set_keys(1'b1, 1'b1, 1'b1);
        idle_frames(3);
        spawn_col = 3'd2; spawn_row = 3'd3;
        clk_cycle(1'b0, 4'b0000);
        do_sof("respawn_sof", 1'b1, 4'b0100, 1'b1);
        chk("respawn.state", int'(state_o), 0);
        chk("respawn.x", int'(topLeftX), 184);
        chk("respawn.y", int'(topLeftY), 264);
        chk("respawn.vy", int'(dut.r_vy), 0);

        // jump tap three frames ahead of the landing
        do_sof("buf3_air", 1'b0, 4'b0000, 1'b0);
        set_keys(1'b1, 1'b1, 1'b0);
        clk_cycle(1'b0, 4'b0000);
        set_keys(1'b1, 1'b1, 1'b1);
        idle_frames(2);
        clk_cycle(1'b1, 4'b0001);
        do_sof("buf3_land", 1'b0, 4'b0000, 1'b0);
        chk("buf3.vy", int'(dut.r_vy), BUF_EN ? 200 : 100);

        // jump tap five frames ahead: expired
        clk_cycle(1'b0, 4'b0000);
        do_respawn("buf5_respawn");
        do_sof("buf5_air", 1'b0, 4'b0000, 1'b0);
        set_keys(1'b1, 1'b1, 1'b0);
        clk_cycle(1'b0, 4'b0000);
        set_keys(1'b1, 1'b1, 1'b1);
        idle_frames(4);
        clk_cycle(1'b1, 4'b0001);
        do_sof("buf5_land", 1'b0, 4'b0000, 1'b0);
        chk("buf5.vy", int'(dut.r_vy), 100);

        // randomized frames
        for (int f = 0; f < 250; f++) begin
            int ncyc;
            ncyc = $urandom_range(1, 4);
            for (int c = 0; c < ncyc; c++) begin
                if ($urandom_range(0, 3) == 0)
                    set_keys($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                             $urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) begin
                    spawn_col = 3'($urandom_range(0, 7));
                    spawn_row = 3'($urandom_range(0, 7));
                    do_respawn("rnd_respawn");
                end else begin
                    clk_cycle($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)));
                end
            end
            if ($urandom_range(0, 29) == 0) begin
                spawn_col = 3'($urandom_range(0, 7));
                spawn_row = 3'($urandom_range(0, 7));
            end
            do_sof("rnd", $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
